// File: rtl/axi_refill_gather.sv
// axi_refill_gather
//   Cache refill shim between an L1 miss port and the AXI AR/R channels.
//   Up to NumOutstanding refills are in flight at once; each one owns a slot
//   whose index is used as the AXI ID. R beats are gathered per ID into a
//   line buffer, and a completed line (or a single non-cacheable word placed
//   at its offset) is returned as a one-cycle pulse with an error flag.
//
//   Ports
//     clk_i, rst_ni, clr_i     clock, async active-low reset, sync clear
//     req_*                    miss request (valid/ready, addr, nc, tid)
//     ar_*                     AXI read address channel (master side)
//     r_*                      AXI read data channel (r_ready_o tied high)
//     rtrn_*                   line return pulse, data, tid, nc, err
//     busy_o                   any slot in use or AR pending
//
//   Slot FSM
//     state        | meaning
//     SLOT_FREE    | unused, may be allocated to a new miss
//     SLOT_WAIT_R  | AR issued or pending, gathering R beats
//     SLOT_DONE    | line complete, waiting for its return cycle
module axi_refill_gather #(
  parameter int LineWidth      = 256,
  parameter int BusWidth       = 64,
  parameter int NumOutstanding = 2,
  parameter int IdWidth        = 4,
  parameter int AddrWidth      = 56,
  parameter int TidWidth       = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_nc_i,
  input  logic [TidWidth-1:0]  req_tid_i,
  output logic                 ar_valid_o,
  input  logic                 ar_ready_i,
  output logic [AddrWidth-1:0] ar_addr_o,
  output logic [7:0]           ar_len_o,
  output logic [2:0]           ar_size_o,
  output logic [IdWidth-1:0]   ar_id_o,
  input  logic                 r_valid_i,
  output logic                 r_ready_o,
  input  logic [BusWidth-1:0]  r_data_i,
  input  logic [IdWidth-1:0]   r_id_i,
  input  logic                 r_last_i,
  input  logic [1:0]           r_resp_i,
  output logic                 rtrn_valid_o,
  output logic [LineWidth-1:0] rtrn_data_o,
  output logic [TidWidth-1:0]  rtrn_tid_o,
  output logic                 rtrn_nc_o,
  output logic                 rtrn_err_o,
  output logic                 busy_o
);

  localparam int Beats   = LineWidth / BusWidth;
  localparam int LineOff = $clog2(LineWidth / 8);
  localparam int BusOff  = $clog2(BusWidth / 8);
  localparam int WordW   = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int SlotW   = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;

  localparam logic [WordW-1:0]     LastIdx  = WordW'(Beats - 1);
  localparam logic [AddrWidth-1:0] LineMask = ~((AddrWidth'(1) << LineOff) - AddrWidth'(1));
  localparam logic [AddrWidth-1:0] BusMask  = ~((AddrWidth'(1) << BusOff) - AddrWidth'(1));

  typedef enum logic [1:0] {
    SLOT_FREE   = 2'd0,
    SLOT_WAIT_R = 2'd1,
    SLOT_DONE   = 2'd2
  } slot_state_e;

  slot_state_e state_q [NumOutstanding];
  slot_state_e state_d [NumOutstanding];

  logic [TidWidth-1:0] slot_tid_q [NumOutstanding];
  logic                slot_nc_q  [NumOutstanding];
  logic [WordW-1:0]    slot_off_q [NumOutstanding];
  logic [WordW-1:0]    slot_cnt_q [NumOutstanding];
  logic                slot_err_q [NumOutstanding];
  logic [BusWidth-1:0] line_q     [NumOutstanding][Beats];

  logic                 ready_q;
  logic                 ar_valid_q;
  logic [AddrWidth-1:0] ar_addr_q;
  logic [7:0]           ar_len_q;
  logic [IdWidth-1:0]   ar_id_q;

  logic                 rtrn_valid_q;
  logic [LineWidth-1:0] rtrn_data_q;
  logic [TidWidth-1:0]  rtrn_tid_q;
  logic                 rtrn_nc_q;
  logic                 rtrn_err_q;

  logic             any_free, any_busy, accept;
  logic [SlotW-1:0] free_idx;
  logic             hit;
  logic [SlotW-1:0] hit_idx;
  logic [WordW-1:0] hit_len, hit_widx;
  logic             at_len, beat_end, beat_bad;
  logic             done_any;
  logic [SlotW-1:0] done_idx;

  logic unused_resp;
  assign unused_resp = r_resp_i[0];

  // Slot selection, beat decode and next-state logic.
  always_comb begin
    any_free = 1'b0;
    any_busy = 1'b0;
    free_idx = '0;
    done_any = 1'b0;
    done_idx = '0;
    hit      = 1'b0;
    hit_idx  = '0;
    for (int k = NumOutstanding - 1; k >= 0; k--) begin
      if (state_q[k] == SLOT_FREE) begin
        any_free = 1'b1;
        free_idx = SlotW'(k);
      end else begin
        any_busy = 1'b1;
      end
      if (state_q[k] == SLOT_DONE) begin
        done_any = 1'b1;
        done_idx = SlotW'(k);
      end
      if (r_valid_i && (r_id_i == IdWidth'(k)) && (state_q[k] == SLOT_WAIT_R)) begin
        hit     = 1'b1;
        hit_idx = SlotW'(k);
      end
    end

    req_ready_o = ready_q & ~clr_i & any_free & ~ar_valid_q;
    accept      = req_valid_i & req_ready_o;

    // A burst ends at r_last or when the expected beat count is reached,
    // whichever comes first; disagreement between the two is an error.
    hit_len  = slot_nc_q[hit_idx] ? '0 : LastIdx;
    at_len   = (slot_cnt_q[hit_idx] == hit_len);
    beat_end = r_last_i | at_len;
    beat_bad = r_last_i ^ at_len;
    hit_widx = slot_nc_q[hit_idx] ? slot_off_q[hit_idx] : slot_cnt_q[hit_idx];

    for (int k = 0; k < NumOutstanding; k++) begin
      state_d[k] = state_q[k];
      unique case (state_q[k])
        SLOT_FREE:   if (accept && (free_idx == SlotW'(k))) state_d[k] = SLOT_WAIT_R;
        SLOT_WAIT_R: if (hit && (hit_idx == SlotW'(k)) && beat_end) state_d[k] = SLOT_DONE;
        SLOT_DONE:   if (done_idx == SlotW'(k)) state_d[k] = SLOT_FREE;
        default:     state_d[k] = SLOT_FREE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumOutstanding; k++) state_q[k] <= SLOT_FREE;
    end else if (clr_i) begin
      for (int k = 0; k < NumOutstanding; k++) state_q[k] <= SLOT_FREE;
    end else begin
      for (int k = 0; k < NumOutstanding; k++) state_q[k] <= state_d[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q      <= 1'b0;
      ar_valid_q   <= 1'b0;
      ar_addr_q    <= '0;
      ar_len_q     <= '0;
      ar_id_q      <= '0;
      rtrn_valid_q <= 1'b0;
      rtrn_data_q  <= '0;
      rtrn_tid_q   <= '0;
      rtrn_nc_q    <= 1'b0;
      rtrn_err_q   <= 1'b0;
      for (int k = 0; k < NumOutstanding; k++) begin
        slot_tid_q[k] <= '0;
        slot_nc_q[k]  <= 1'b0;
        slot_off_q[k] <= '0;
        slot_cnt_q[k] <= '0;
        slot_err_q[k] <= 1'b0;
        for (int w = 0; w < Beats; w++) line_q[k][w] <= '0;
      end
    end else if (clr_i) begin
      ready_q      <= 1'b0;
      ar_valid_q   <= 1'b0;
      ar_addr_q    <= '0;
      ar_len_q     <= '0;
      ar_id_q      <= '0;
      rtrn_valid_q <= 1'b0;
      rtrn_data_q  <= '0;
      rtrn_tid_q   <= '0;
      rtrn_nc_q    <= 1'b0;
      rtrn_err_q   <= 1'b0;
      for (int k = 0; k < NumOutstanding; k++) begin
        slot_tid_q[k] <= '0;
        slot_nc_q[k]  <= 1'b0;
        slot_off_q[k] <= '0;
        slot_cnt_q[k] <= '0;
        slot_err_q[k] <= 1'b0;
        for (int w = 0; w < Beats; w++) line_q[k][w] <= '0;
      end
    end else begin
      ready_q <= 1'b1;

      // AR register: loaded on accept, emptied on handshake. Accept is only
      // possible while it is empty, so the two never collide.
      if (accept) begin
        ar_valid_q <= 1'b1;
        ar_addr_q  <= req_nc_i ? (req_addr_i & BusMask) : (req_addr_i & LineMask);
        ar_len_q   <= req_nc_i ? 8'd0 : 8'(Beats - 1);
        ar_id_q    <= IdWidth'(free_idx);
        slot_tid_q[free_idx] <= req_tid_i;
        slot_nc_q[free_idx]  <= req_nc_i;
        slot_off_q[free_idx] <= req_nc_i ?
                                WordW'((req_addr_i >> BusOff) & AddrWidth'(Beats - 1)) : '0;
        slot_cnt_q[free_idx] <= '0;
        slot_err_q[free_idx] <= 1'b0;
      end else if (ar_valid_q && ar_ready_i) begin
        ar_valid_q <= 1'b0;
      end

      if (hit) begin
        line_q[hit_idx][hit_widx] <= r_data_i;
        slot_cnt_q[hit_idx]       <= slot_cnt_q[hit_idx] + 1'b1;
        slot_err_q[hit_idx]       <= slot_err_q[hit_idx] | r_resp_i[1] | beat_bad;
      end

      // Return data is copied out so the slot can be reused immediately.
      rtrn_valid_q <= done_any;
      if (done_any) begin
        for (int w = 0; w < Beats; w++) rtrn_data_q[w*BusWidth +: BusWidth] <= line_q[done_idx][w];
        rtrn_tid_q <= slot_tid_q[done_idx];
        rtrn_nc_q  <= slot_nc_q[done_idx];
        rtrn_err_q <= slot_err_q[done_idx];
      end
    end
  end

  // Beats for unknown IDs or idle slots are consumed and dropped.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !clr_i && r_valid_i) begin
      assert (hit) else $warning("axi_refill_gather: dropped R beat with id %0d", r_id_i);
    end
  end

  assign ar_valid_o   = ar_valid_q;
  assign ar_addr_o    = ar_addr_q;
  assign ar_len_o     = ar_len_q;
  assign ar_size_o    = 3'(BusOff);
  assign ar_id_o      = ar_id_q;
  assign r_ready_o    = 1'b1;
  assign rtrn_valid_o = rtrn_valid_q;
  assign rtrn_data_o  = rtrn_data_q;
  assign rtrn_tid_o   = rtrn_tid_q;
  assign rtrn_nc_o    = rtrn_nc_q;
  assign rtrn_err_o   = rtrn_err_q;
  assign busy_o       = any_busy | ar_valid_q;

endmodule

// File: tb/tb_axi_refill_gather.sv
// Testbench for axi_refill_gather with default parameters.
module tb_axi_refill_gather;

  logic         clk = 1'b0;
  logic         rst_n, clr;
  logic         req_valid, req_ready, req_nc;
  logic [55:0]  req_addr;
  logic [1:0]   req_tid;
  logic         ar_valid, ar_ready;
  logic [55:0]  ar_addr;
  logic [7:0]   ar_len;
  logic [2:0]   ar_size;
  logic [3:0]   ar_id;
  logic         r_valid, r_ready, r_last;
  logic [63:0]  r_data;
  logic [3:0]   r_id;
  logic [1:0]   r_resp;
  logic         rtrn_valid, rtrn_nc, rtrn_err, busy;
  logic [255:0] rtrn_data;
  logic [1:0]   rtrn_tid;

  always #5 clk = ~clk;

  axi_refill_gather dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_nc_i(req_nc), .req_tid_i(req_tid),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr),
    .ar_len_o(ar_len), .ar_size_o(ar_size), .ar_id_o(ar_id),
    .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_id_i(r_id),
    .r_last_i(r_last), .r_resp_i(r_resp),
    .rtrn_valid_o(rtrn_valid), .rtrn_data_o(rtrn_data), .rtrn_tid_o(rtrn_tid),
    .rtrn_nc_o(rtrn_nc), .rtrn_err_o(rtrn_err), .busy_o(busy)
  );

  typedef struct {
    logic [255:0] data;
    logic [3:0]   mask;
    logic [1:0]   tid;
    logic         nc;
    logic         err;
  } exp_t;

  typedef struct {
    logic [55:0] addr;
    logic        nc;
    logic [1:0]  tid;
    int          nbeats;
    int          last_at;
    int          err_beat;
    int          off;
    logic [55:0] ar_addr;
    logic [7:0]  len;
    logic        err;
    logic [3:0]  mask;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   pulses = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Scoreboard: every return pulse must match the oldest pending expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    logic [255:0] m;
    if (rtrn_valid) begin
      pulses++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rtrn_unexpected: got pulse tid=%0d, required no pulse", rtrn_tid);
      end else begin
        e = sb.pop_front();
        m = '0;
        for (int w = 0; w < 4; w++) if (e.mask[w]) m[w*64 +: 64] = '1;
        if (rtrn_tid !== e.tid || rtrn_nc !== e.nc || rtrn_err !== e.err ||
            (rtrn_data & m) !== (e.data & m)) begin
          bad++;
          $display("FAIL rtrn_line: got tid=%0d nc=%0d err=%0d data=%h, required tid=%0d nc=%0d err=%0d data=%h mask=%h",
                   rtrn_tid, rtrn_nc, rtrn_err, rtrn_data, e.tid, e.nc, e.err, e.data, e.mask);
        end
      end
    end
  end

  task automatic send_req(input logic [55:0] a, input logic nc, input logic [1:0] tid);
    int to = 0;
    while (!req_ready && to < 20) begin
      @(posedge clk); #1;
      to++;
    end
    check("req_ready_before_accept", req_ready, 1);
    req_valid = 1; req_addr = a; req_nc = nc; req_tid = tid;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic beat(input logic [3:0] id, input logic [63:0] d, input logic last, input logic [1:0] resp);
    r_valid = 1; r_id = id; r_data = d; r_last = last; r_resp = resp;
    @(posedge clk); #1;
    r_valid = 0; r_last = 0; r_resp = 2'b00;
  endtask

  task automatic drain(input string name);
    int to = 0;
    while (sb.size() != 0 && to < 30) begin
      @(posedge clk); #1;
      to++;
    end
    check(name, sb.size(), 0);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    exp_t e;
    logic [63:0] words [4];
    int pos;
    send_req(v.addr, v.nc, v.tid);
    check($sformatf("ar_fields[%0d]", i), {ar_valid, ar_addr, ar_len, ar_size, ar_id},
          {1'b1, v.ar_addr, v.len, 3'd3, 4'd0});
    e.data = '0; e.mask = v.mask; e.tid = v.tid; e.nc = v.nc; e.err = v.err;
    for (int b = 0; b < 4; b++) words[b] = {$urandom, $urandom};
    for (int b = 0; b < v.nbeats; b++) begin
      pos = v.nc ? v.off : b;
      e.data[pos*64 +: 64] = words[b];
    end
    sb.push_back(e);
    for (int b = 0; b < v.nbeats; b++)
      beat(4'd0, words[b], (b == v.last_at), (b == v.err_beat) ? 2'b10 : 2'b00);
    check($sformatf("rtrn_not_early[%0d]", i), rtrn_valid, 0);
    @(posedge clk); #1;
    check($sformatf("rtrn_pulse[%0d]", i), rtrn_valid, 1);
    @(posedge clk); #1;
    check($sformatf("idle_after_rtrn[%0d]", i), {busy, req_ready, sb.size() == 0}, 3'b011);
  endtask

  vec_t vecs[10];

  initial begin
    exp_t e0, e1;
    logic [63:0] d0 [4];
    logic [63:0] d1 [4];
    int ids[8];
    int c0, c1, p0;

    vecs[0] = '{56'h80001234, 1'b0, 2'd0, 4, 3, -1, 0, 56'h80001220, 8'd3, 1'b0, 4'hF};
    vecs[1] = '{56'h10000018, 1'b1, 2'd1, 1, 0, -1, 3, 56'h10000018, 8'd0, 1'b0, 4'h8};
    vecs[2] = '{56'h0000003F, 1'b0, 2'd2, 4, 3, -1, 0, 56'h00000020, 8'd3, 1'b0, 4'hF};
    vecs[3] = '{56'h00000007, 1'b1, 2'd3, 1, 0, -1, 0, 56'h00000000, 8'd0, 1'b0, 4'h1};
    vecs[4] = '{56'hFFFFFFFFFFFFFF, 1'b0, 2'd1, 4, 3, -1, 0, 56'hFFFFFFFFFFFFE0, 8'd3, 1'b0, 4'hF};
    vecs[5] = '{56'h0000000F, 1'b1, 2'd2, 1, 0, -1, 1, 56'h00000008, 8'd0, 1'b0, 4'h2};
    vecs[6] = '{56'h00002000, 1'b0, 2'd3, 4, 3, 2, 0, 56'h00002000, 8'd3, 1'b1, 4'hF};
    vecs[7] = '{56'h00003008, 1'b0, 2'd0, 2, 1, -1, 0, 56'h00003000, 8'd3, 1'b1, 4'h3};
    vecs[8] = '{56'h00004010, 1'b0, 2'd1, 4, -1, -1, 0, 56'h00004000, 8'd3, 1'b1, 4'hF};
    vecs[9] = '{56'h00000028, 1'b1, 2'd0, 1, 0, 0, 1, 56'h00000028, 8'd0, 1'b1, 4'h2};

    rst_n = 0; clr = 0; req_valid = 0; req_addr = '0; req_nc = 0; req_tid = '0;
    ar_ready = 1; r_valid = 0; r_data = '0; r_id = '0; r_last = 0; r_resp = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {req_ready, ar_valid, rtrn_valid, busy, rtrn_tid, rtrn_nc, rtrn_err, r_ready},
          {7'b0, 1'b1});
    check("reset_data", rtrn_data, 0);
    rst_n = 1;
    @(posedge clk); #1;
    check("ready_after_reset", req_ready, 1);

    // Table-driven single refills
    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Two outstanding refills, id1 completes first
    for (int b = 0; b < 4; b++) begin
      d0[b] = {$urandom, $urandom};
      d1[b] = {$urandom, $urandom};
    end
    send_req(56'h1000, 1'b0, 2'd1);
    check("two_ar0", {ar_valid, ar_addr, ar_id}, {1'b1, 56'h1000, 4'd0});
    send_req(56'h2040, 1'b0, 2'd2);
    check("two_ar1", {ar_valid, ar_addr, ar_id}, {1'b1, 56'h2040, 4'd1});
    e1.data = {d1[3], d1[2], d1[1], d1[0]}; e1.mask = 4'hF; e1.tid = 2'd2; e1.nc = 0; e1.err = 0;
    e0.data = {d0[3], d0[2], d0[1], d0[0]}; e0.mask = 4'hF; e0.tid = 2'd1; e0.nc = 0; e0.err = 0;
    sb.push_back(e1);
    sb.push_back(e0);
    ids = '{1, 0, 1, 1, 0, 1, 0, 0};
    c0 = 0; c1 = 0;
    for (int k = 0; k < 8; k++) begin
      if (ids[k] == 1) begin
        beat(4'd1, d1[c1], (c1 == 3), 2'b00);
        c1++;
      end else begin
        beat(4'd0, d0[c0], (c0 == 3), 2'b00);
        c0++;
      end
      if (k == 0) check("ready_low_both_busy", {req_ready, busy}, 2'b01);
    end
    drain("two_drain");

    // AR stall
    ar_ready = 0;
    send_req(56'h4444, 1'b0, 2'd0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("ar_stall[%0d]", k), {ar_valid, ar_addr, ar_len, ar_id, req_ready, busy},
            {1'b1, 56'h4440, 8'd3, 4'd0, 1'b0, 1'b1});
      @(posedge clk); #1;
    end
    ar_ready = 1;
    @(posedge clk); #1;
    check("ar_released", {ar_valid, busy}, 2'b01);
    e0.data = {d1[0], d0[2], d1[3], d0[1]}; e0.mask = 4'hF; e0.tid = 2'd0; e0.nc = 0; e0.err = 0;
    sb.push_back(e0);
    beat(4'd0, d0[1], 1'b0, 2'b00);
    beat(4'd0, d1[3], 1'b0, 2'b00);
    beat(4'd0, d0[2], 1'b0, 2'b00);
    beat(4'd0, d1[0], 1'b1, 2'b00);
    drain("stall_drain");

    // Reset in the middle of a burst
    send_req(56'h5000, 1'b0, 2'd1);
    beat(4'd0, d0[0], 1'b0, 2'b00);
    beat(4'd0, d0[1], 1'b0, 2'b00);
    p0 = pulses;
    rst_n = 0;
    @(posedge clk); #1;
    check("mid_reset_outputs", {ar_valid, busy, req_ready, rtrn_valid}, 4'b0000);
    rst_n = 1;
    beat(4'd0, d0[2], 1'b0, 2'b00);
    beat(4'd0, d0[3], 1'b1, 2'b00);
    repeat (5) @(posedge clk);
    #1;
    check("no_stale_rtrn", pulses, p0);
    check("idle_after_stale", {busy, req_ready}, 2'b01);
    run_vec(10, vecs[0]);

    // Synchronous clear drops a pending request
    send_req(56'h6000, 1'b0, 2'd3);
    clr = 1;
    #1;
    check("ready_low_in_clr", req_ready, 0);
    @(posedge clk); #1;
    clr = 0;
    check("clr_state", {ar_valid, busy, req_ready}, 3'b000);
    @(posedge clk); #1;
    check("ready_after_clr", req_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("sb_empty_end", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
